// File: rtl/store_buffer_pkg.sv
// Shared sizing and entry type for the store buffer.
// Buffer geometry is fixed here so the entry struct and all users agree.
package store_buffer_pkg;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Address compare of a load against every buffered store, returning the youngest match.
// hit_data is only consumed when STORE_BUFFER_FWD_EN is defined.
module sb_match
  import store_buffer_pkg::*;
(
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic      [DEPTH-1:0] valid,
  input  logic      [PTR_W-1:0] wr_ptr,
  input  logic      [AW-1:0]    ld_a,
  output logic                  hit,
  output logic      [DW-1:0]    hit_data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the youngest matching entry is the last one written.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = int'(DEPTH); i > 0; i--) begin
      idx = wr_ptr - PTR_W'(i);
      if (valid[idx] && (entries[idx].addr == ld_a)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store path and a single-port data memory.
// STORE_BUFFER_FWD_EN: forward youngest matching store to loads instead of stalling them.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  input  logic [AW-1:0] st_a,
  input  logic [DW-1:0] st_wd,
  output logic          st_ready,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_a,
  output logic [DW-1:0] ld_rd,
  output logic          ld_stall,
  output logic          busy,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  sb_entry_t [DEPTH-1:0] entries_q;
  logic      [DEPTH-1:0] valid_q;
  logic      [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic      [CNT_W-1:0] count_q;

  sb_entry_t     head;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          push, pop, load_cycle;

  assign head = entries_q[rd_ptr_q];

  sb_match u_match (
    .entries  (entries_q),
    .valid    (valid_q),
    .wr_ptr   (wr_ptr_q),
    .ld_a     (ld_a),
    .hit      (hit),
    .hit_data (hit_data)
  );

  // Outputs are masked during reset so a reset cycle never issues a write or a stall.
  assign st_ready = rst || (count_q < CNT_W'(DEPTH));
  assign busy     = !rst && (count_q != '0);

`ifdef STORE_BUFFER_FWD_EN
  assign ld_stall = 1'b0;
  assign ld_rd    = (!rst && hit) ? hit_data : mem_rd;
`else
  logic unused_hit_data;
  assign unused_hit_data = ^hit_data;
  assign ld_stall = !rst && ld_en && hit;
  assign ld_rd    = mem_rd;
`endif

  assign load_cycle = ld_en && !ld_stall;
  assign pop        = !rst && (count_q != '0) && !load_cycle;
  assign push       = !rst && st_valid && st_ready;

  assign mem_we = pop;
  assign mem_a  = pop ? head.addr : ld_a;
  assign mem_wd = pop ? head.data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wr_ptr_q] <= '{addr: st_a, data: st_wd};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural data memory and golden memory image.
// Expectations for same-address loads follow STORE_BUFFER_FWD_EN.
module tb_store_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       st_valid;
  logic [7:0] st_a, st_wd;
  logic       st_ready;
  logic       ld_en;
  logic [7:0] ld_a, ld_rd;
  logic       ld_stall, busy;
  logic [7:0] mem_a, mem_wd;
  logic       mem_we;
  logic [7:0] mem_rd;

  logic [7:0] mem  [256] = '{default: 8'h00};
  logic [7:0] gold [256] = '{default: 8'h00};
  int n_vec  = 0;
  int n_err  = 0;
  int n_wr   = 0;
  int exp_wr = 0;

  store_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_a     (st_a),
    .st_wd    (st_wd),
    .st_ready (st_ready),
    .ld_en    (ld_en),
    .ld_a     (ld_a),
    .ld_rd    (ld_rd),
    .ld_stall (ld_stall),
    .busy     (busy),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a] <= mem_wd;
      n_wr       <= n_wr + 1;
    end
  end
  assign mem_rd = mem[mem_a];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // One store; hold=1 keeps an unmatched load on the port so nothing drains this cycle.
  task automatic push(input logic [7:0] a, input logic [7:0] d, input bit hold, input bit commit);
    st_valid = 1'b1;
    st_a     = a;
    st_wd    = d;
    ld_en    = hold;
    ld_a     = 8'hFF;
    #1;
    check("push_ready", st_ready, 1);
    if (commit) begin
      gold[a] = d;
      exp_wr++;
    end
    cyc;
    st_valid = 1'b0;
    ld_en    = 1'b0;
  endtask

  task automatic drain_exp(input logic [7:0] a, input logic [7:0] d);
    #1;
    check("drain_we", mem_we, 1);
    check("drain_a", mem_a, a);
    check("drain_wd", mem_wd, d);
    cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_a = '0; st_wd = '0; ld_en = 1'b0; ld_a = '0;
    cyc;
    #1;
    check("rst_ready", st_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_stall", ld_stall, 0);
    cyc;
    rst = 1'b0;

    // Reset mid-drain with three entries buffered.
    push(8'h01, 8'h51, 1, 1);
    push(8'h02, 8'h52, 1, 0);
    push(8'h03, 8'h53, 1, 0);
    drain_exp(8'h01, 8'h51);
    rst = 1'b1;
    #1;
    check("midrst_we", mem_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", st_ready, 1);
    cyc;
    cyc;
    rst = 1'b0;
    #1;
    check("postrst_busy", busy, 0);
    check("postrst_we", mem_we, 0);
    check("postrst_ready", st_ready, 1);
    cyc;

    // Fill to full, then drain in FIFO order.
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 8'(8'hA0 + i), 1, 1);
    #1;
    check("full_ready", st_ready, 0);
    check("full_busy", busy, 1);
    for (int i = 0; i < 4; i++) drain_exp(8'(8'h10 + i), 8'(8'hA0 + i));
    #1;
    check("empty_busy", busy, 0);
    check("empty_we", mem_we, 0);

    // Two stores to the same address, then a load of it.
    push(8'h20, 8'h11, 1, 1);
    push(8'h20, 8'h22, 1, 1);
    ld_en = 1'b1;
    ld_a  = 8'h20;
    #1;
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_stall", ld_stall, 0);
    check("fwd_rd", ld_rd, 8'h22);
    check("fwd_we", mem_we, 0);
    cyc;
    ld_en = 1'b0;
    drain_exp(8'h20, 8'h11);
    drain_exp(8'h20, 8'h22);
`else
    check("stall_1", ld_stall, 1);
    drain_exp(8'h20, 8'h11);
    #1;
    check("stall_2", ld_stall, 1);
    drain_exp(8'h20, 8'h22);
`endif
    ld_en = 1'b1;
    ld_a  = 8'h20;
    #1;
    check("ld_after_drain_stall", ld_stall, 0);
    check("ld_after_drain_rd", ld_rd, 8'h22);
    check("ld_after_drain_we", mem_we, 0);
    cyc;
    ld_en = 1'b0;

    // Unmatched loads block draining without stalling.
    push(8'h40, 8'h77, 0, 1);
    drain_exp(8'h40, 8'h77);
    push(8'h30, 8'hB0, 1, 1);
    push(8'h31, 8'hB1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      ld_en = 1'b1;
      ld_a  = 8'h40;
      #1;
      check("ldblk_we", mem_we, 0);
      check("ldblk_rd", ld_rd, 8'h77);
      check("ldblk_busy", busy, 1);
      check("ldblk_stall", ld_stall, 0);
      cyc;
    end
    ld_en = 1'b0;
    drain_exp(8'h30, 8'hB0);
    drain_exp(8'h31, 8'hB1);
    #1;
    check("ldblk_done", busy, 0);

    // Full buffer with a store held while draining.
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i), 8'(8'hC0 + i), 1, 1);
    st_valid = 1'b1;
    st_a     = 8'h50;
    st_wd    = 8'hC4;
    #1;
    check("hold_ready0", st_ready, 0);
    check("hold_we0", mem_we, 1);
    check("hold_a0", mem_a, 8'h60);
    cyc;
    #1;
    check("hold_ready1", st_ready, 1);
    check("hold_a1", mem_a, 8'h61);
    gold[8'h50] = 8'hC4;
    exp_wr++;
    cyc;
    st_valid = 1'b0;
    drain_exp(8'h62, 8'hC2);
    drain_exp(8'h63, 8'hC3);
    drain_exp(8'h50, 8'hC4);
    #1;
    check("hold_done", busy, 0);

    // Interleaved store/drain across several pointer wraps.
    for (int i = 0; i < 10; i++) push(8'(8'h80 + i % 3), 8'(i * 7 + 1), 0, 1);
    for (int k = 0; k < 20 && busy; k++) cyc;
    check("wrap_done", busy, 0);
    check("write_count", n_wr, exp_wr);

    for (int a = 0; a < 256; a++) begin
      ld_en = 1'b1;
      ld_a  = 8'(a);
      #1;
      check("mem_image", ld_rd, gold[a]);
      cyc;
    end
    ld_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
